// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_muldiv execute unit.
//   - 5-bit operation codes (RV32I integer subset plus RV32M)
//   - FSM state encoding
//   - is_mul / is_div op classifiers
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned restoring divider, one quotient bit per cycle.
// The first iteration is performed on the start edge itself, so done pulses
// XLEN-1 cycles after start and quotient/remainder are valid while done=1.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (aborts)
//   start           load dividend/divisor magnitudes and begin
//   dividend        unsigned dividend (sampled on start)
//   divisor         unsigned divisor, must be non-zero (sampled on start)
//   done            one-cycle pulse, results valid
//   quotient        unsigned quotient
//   remainder       unsigned remainder
module alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, dvd_q, dvs_q;
  logic [CW-1:0]   cnt;
  logic            busy;

  logic [XLEN-1:0] st_rem, st_dvd, st_dvs;
  logic [XLEN-1:0] nx_rem, nx_dvd;
  logic [XLEN:0]   shifted, diff;

  // One restoring step. The dividend register shifts left and collects
  // quotient bits at its LSB, so after XLEN steps it holds the quotient.
  always_comb begin
    st_rem  = start ? '0 : rem_q;
    st_dvd  = start ? dividend : dvd_q;
    st_dvs  = start ? divisor : dvs_q;
    shifted = {st_rem, st_dvd[XLEN-1]};
    diff    = shifted - {1'b0, st_dvs};
    if (!diff[XLEN]) begin
      nx_rem = diff[XLEN-1:0];
      nx_dvd = {st_dvd[XLEN-2:0], 1'b1};
    end else begin
      nx_rem = shifted[XLEN-1:0];
      nx_dvd = {st_dvd[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= nx_rem;
        dvd_q <= nx_dvd;
        dvs_q <= divisor;
        cnt   <= CW'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= nx_rem;
        dvd_q <= nx_dvd;
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(XLEN-1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = dvd_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: sequential RV32I/RV32M execute unit with valid/ready handshake.
// Integer ops, illegal ops and divide early-outs finish one cycle after
// accept; iterative multiply/divide finish XLEN+1 cycles after accept.
// Optional build macro ALU_FAST_MUL_EN: multiplies use a single-cycle
// combinational multiplier and the MUL state is not built.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (op, op_a, op_b latched on accept)
//   op                   5-bit op code (alu_pkg)
//   op_a, op_b           operands
//   out_valid/out_ready  result handshake
//   result, zero, illegal registered outputs, held until taken
module alu_muldiv #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  import alu_pkg::*;

  state_t          state, next_state;
  logic            accept;
  logic [XLEN-1:0] int_res, mag_a, mag_b, early_res, div_res, res_val;
  logic [SHAMT_W-1:0] shamt;
  logic            sgn_a, sgn_b, signed_div, div_zero, div_ovf, want_rem_in;
  logic            mul_hi_in;
  logic            res_load, ill_val, div_start, div_done;
  logic            q_neg, r_neg, want_rem;
  logic [XLEN-1:0] quo, rem_mag;

  // Negate a 2*XLEN magnitude product if needed and pick the requested half.
  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                               input logic neg, input logic hi);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
  endfunction

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = op_b[SHAMT_W-1:0];

  // Operand signedness per op. MUL is treated as signed x signed; its low
  // half is identical to the unsigned product anyway.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = op_a[XLEN-1];
        sgn_b = op_b[XLEN-1];
      end
      OP_MULHSU: sgn_a = op_a[XLEN-1];
      default: ;
    endcase
  end

  // The most-negative value negates to itself, which is its correct
  // unsigned magnitude.
  assign mag_a       = sgn_a ? -op_a : op_a;
  assign mag_b       = sgn_b ? -op_b : op_b;
  assign mul_hi_in   = (op != OP_MUL);
  assign signed_div  = (op == OP_DIV) || (op == OP_REM);
  assign want_rem_in = (op == OP_REM) || (op == OP_REMU);
  assign div_zero    = (op_b == '0);
  assign div_ovf     = signed_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign early_res   = div_zero ? (want_rem_in ? op_a : '1)
                                : (want_rem_in ? '0 : op_a);

  always_comb begin
    int_res = '0;
    case (op)
      OP_ADD:  int_res = op_a + op_b;
      OP_SUB:  int_res = op_a - op_b;
      OP_SLL:  int_res = op_a << shamt;
      OP_SLT:  int_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: int_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  int_res = op_a ^ op_b;
      OP_SRL:  int_res = op_a >> shamt;
      OP_SRA:  int_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   int_res = op_a | op_b;
      OP_AND:  int_res = op_a & op_b;
      default: int_res = '0;
    endcase
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_res  = mul_pick(fast_prod, sgn_a ^ sgn_b, mul_hi_in);
`else
  localparam int CW = $clog2(XLEN);
  logic [2*XLEN-1:0] mcand, prod, prod_next;
  logic [XLEN-1:0]   mplier, mul_res;
  logic [CW-1:0]     mul_cnt;
  logic              mul_neg, mul_hi, mul_start, mul_last;

  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign mul_last  = (state == S_MUL) && (mul_cnt == CW'(XLEN-1));
  assign mul_res   = mul_pick(prod_next, mul_neg, mul_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
      mul_cnt <= '0;
      mul_neg <= 1'b0;
      mul_hi  <= 1'b0;
    end else if (mul_start) begin
      mcand   <= {{XLEN{1'b0}}, mag_a};
      mplier  <= mag_b;
      prod    <= '0;
      mul_cnt <= '0;
      mul_neg <= sgn_a ^ sgn_b;
      mul_hi  <= mul_hi_in;
    end else if (state == S_MUL) begin
      prod    <= prod_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + 1'b1;
    end
  end
`endif

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem_mag)
  );

  assign div_res = want_rem ? (r_neg ? -rem_mag : rem_mag)
                            : (q_neg ? -quo : quo);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    res_load   = 1'b0;
    res_val    = '0;
    ill_val    = 1'b0;
    div_start  = 1'b0;
`ifndef ALU_FAST_MUL_EN
    mul_start  = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE && out_ready) next_state = S_IDLE;
        if (accept) begin
          if (op > OP_REMU) begin
            next_state = S_DONE;
            res_load   = 1'b1;
            ill_val    = 1'b1;
          end else if (is_div(op)) begin
            if (div_zero || div_ovf) begin
              next_state = S_DONE;
              res_load   = 1'b1;
              res_val    = early_res;
            end else begin
              next_state = S_DIV;
              div_start  = 1'b1;
            end
          end else if (is_mul(op)) begin
`ifdef ALU_FAST_MUL_EN
            next_state = S_DONE;
            res_load   = 1'b1;
            res_val    = fast_res;
`else
            next_state = S_MUL;
            mul_start  = 1'b1;
`endif
          end else begin
            next_state = S_DONE;
            res_load   = 1'b1;
            res_val    = int_res;
          end
        end
      end
`ifndef ALU_FAST_MUL_EN
      S_MUL: begin
        if (mul_last) begin
          next_state = S_DONE;
          res_load   = 1'b1;
          res_val    = mul_res;
        end
      end
`endif
      S_DIV: begin
        if (div_done) begin
          next_state = S_DONE;
          res_load   = 1'b1;
          res_val    = div_res;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Result registers; zero is recomputed on every write.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      want_rem <= 1'b0;
    end else begin
      if (res_load) begin
        result  <= res_val;
        zero    <= (res_val == '0);
        illegal <= ill_val;
      end
      if (div_start) begin
        q_neg    <= sgn_a ^ sgn_b;
        r_neg    <= sgn_a;
        want_rem <= want_rem_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv (XLEN=32).
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid, zero, illegal;
  logic [4:0]  op;
  logic [31:0] op_a, op_b, result;
  int checks = 0;
  int errors = 0;

`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [4:0]  INT_OP [10] = '{OP_ADD, OP_SUB, OP_SRA, OP_SRL, OP_SLL,
                                          OP_SLT, OP_SLTU, OP_XOR, OP_AND, OP_OR};
  localparam logic [31:0] INT_A  [10] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1,
                                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0};
  localparam logic [31:0] INT_B  [10] = '{32'd1, 32'd5, 32'd4, 32'd4, 32'd33,
                                          32'd1, 32'd1, 32'hFF00, 32'hFF00, 32'hFF00};
  localparam logic [31:0] INT_E  [10] = '{32'h8000_0000, 32'd0, 32'hF800_0000, 32'h0800_0000, 32'd2,
                                          32'd1, 32'd0, 32'h0FF0, 32'hF000, 32'hFFF0};

  localparam logic [4:0]  MUL_OP [4] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU};
  localparam logic [31:0] MUL_A  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
  localparam logic [31:0] MUL_B  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd2};
  localparam logic [31:0] MUL_E  [4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFF};

  localparam logic [4:0]  DIV_OP [8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
  localparam logic [31:0] DIV_A  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                         32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100};
  localparam logic [31:0] DIV_B  [8] = '{32'd2, 32'd2, 32'd0, 32'd0,
                                         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7};
  localparam logic [31:0] DIV_E  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                                         32'h8000_0000, 32'd0, 32'd14, 32'd2};
  localparam int          DIV_L  [8] = '{33, 33, 1, 1, 1, 1, 33, 33};

  // Present one request from IDLE, count cycles to out_valid (bounded).
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset result got %h want 0", result); end
    checks++; if (zero !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset zero/illegal got %b/%b want 0/0", zero, illegal); end
  endtask

  task automatic test_int();
    logic [31:0] r; int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(INT_OP[i], INT_A[i], INT_B[i], r, lat);
      checks++; if (r !== INT_E[i]) begin errors++; $display("FAIL int[%0d] result got %h want %h", i, r, INT_E[i]); end
      checks++; if (zero !== (INT_E[i] == 0)) begin errors++; $display("FAIL int[%0d] zero got %b want %b", i, zero, INT_E[i] == 0); end
      checks++; if (lat != 1) begin errors++; $display("FAIL int[%0d] latency got %0d want 1", i, lat); end
      take_result();
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(MUL_OP[i], MUL_A[i], MUL_B[i], r, lat);
      checks++; if (r !== MUL_E[i]) begin errors++; $display("FAIL mul[%0d] result got %h want %h", i, r, MUL_E[i]); end
      checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, MUL_LAT); end
      take_result();
    end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(DIV_OP[i], DIV_A[i], DIV_B[i], r, lat);
      checks++; if (r !== DIV_E[i]) begin errors++; $display("FAIL div[%0d] result got %h want %h", i, r, DIV_E[i]); end
      checks++; if (zero !== (DIV_E[i] == 0)) begin errors++; $display("FAIL div[%0d] zero got %b want %b", i, zero, DIV_E[i] == 0); end
      checks++; if (lat != DIV_L[i]) begin errors++; $display("FAIL div[%0d] latency got %0d want %0d", i, lat, DIV_L[i]); end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat;
    run_op(OP_ADD, 32'd1, 32'd2, r, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL hold[%0d] result/valid got %h/%b want 3/1", i, result, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold[%0d] in_ready got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1; op = OP_ADD; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++; $display("FAIL b2b result/valid got %h/%b want 1e/1", result, out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] r; int lat;
    op = OP_DIVU; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL middiv busy ready/valid got %b/%b want 0/0", in_ready, out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL middiv valid/ready got %b/%b want 0/1", out_valid, in_ready); end
    checks++; if (result !== 32'd0 || zero !== 1'b0) begin errors++; $display("FAIL middiv result/zero got %h/%b want 0/0", result, zero); end
    run_op(OP_ADD, 32'd2, 32'd3, r, lat);
    checks++; if (r !== 32'd5 || lat != 1) begin errors++; $display("FAIL postrst add got %h lat %0d want 5 lat 1", r, lat); end
    take_result();
  endtask

  task automatic test_illegal();
    logic [31:0] r; int lat;
    run_op(5'd25, 32'h1234, 32'h5678, r, lat);
    checks++; if (r !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL illegal result/zero got %h/%b want 0/1", r, zero); end
    checks++; if (illegal !== 1'b1 || lat != 1) begin errors++; $display("FAIL illegal flag/lat got %b/%0d want 1/1", illegal, lat); end
    take_result();
    run_op(OP_ADD, 32'd2, 32'd3, r, lat);
    checks++; if (illegal !== 1'b0 || r !== 32'd5 || zero !== 1'b0) begin errors++; $display("FAIL illegal clear flag/result/zero got %b/%h/%b want 0/5/0", illegal, r, zero); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_int();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, sequential successor to the core combinational ALU.
- Executes RV32I integer ops and the RV32M multiply/divide ops behind a valid/ready handshake on both input and output.
- Integer ops complete in 1 cycle; multiply and divide iterate one bit per cycle.
- Sits in the EX stage. The pipeline stalls while in_ready or out_valid is low.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2, ≥8.
- SHAMT_W, $clog2(XLEN), number of shift-amount bits taken from op_b.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- op  input  5  operation code (see package)
- op_a  input  XLEN  operand A
- op_b  input  XLEN  operand B
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes result this cycle
- result  output  XLEN  registered result
- zero  output  1  registered, result==0
- illegal  output  1  registered, op code not defined

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, zero=0, illegal=0, in_ready=1.
- Accept: a request is accepted when in_valid && in_ready. Operands and op are latched on acceptance.
- in_ready: 1 in IDLE, or in DONE when out_ready=1 (back-to-back accept). 0 in MUL and DIV.
- States: IDLE, MUL, DIV, DONE.
  - IDLE→DONE for integer ops, illegal ops and div early-outs.
  - IDLE→MUL / IDLE→DIV for M ops.
  - MUL/DIV→DONE when the iteration count reaches XLEN.
  - DONE→IDLE on out_ready with no new accept; DONE→next state on a simultaneous accept.
- Latency from the accept edge to out_valid=1:
  - 1 cycle for integer ops, illegal ops and div early-outs.
  - XLEN+1 cycles for iterative mul/div.
- Output hold: result, zero and illegal stay stable while out_valid && !out_ready.
- Integer ops:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is signed; SLTU is unsigned. Both produce 0 or 1.
  - SLL/SRL/SRA use op_b[SHAMT_W-1:0] only. SRL is logical (zero fill); SRA is arithmetic (sign fill).
- Multiply: unsigned shift-add on operand magnitudes, 2*XLEN-bit product, sign fixed at the end.
  - MUL returns the low half.
  - MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned; each returns the high half.
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign_a^sign_b; remainder takes the sign of the dividend.
  - Divide by zero (1-cycle early-out): quotient=all ones, remainder=op_a.
  - Signed overflow, op_a=most-negative and op_b=-1 (1-cycle early-out): quotient=op_a, remainder=0.
- Illegal op (codes 18–31): result=0, zero=1, illegal=1, latency 1.
- zero is recomputed every time result is written. It is never left sticky.
- Reset mid-operation: asserting rst in MUL or DIV aborts the operation. The next cycle is IDLE with all outputs at their reset values; no partial result appears.
- in_valid while in_ready=0 is ignored. The requester must hold its request.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN combinational multiplier, latency 1; state MUL is not built.
- Undefined: iterative multiply as above, latency XLEN+1.
- Divide is iterative in both builds.

Decomposition:
- Package alu_pkg:
  - Op-code constants, 5-bit: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17.
  - State enum.
  - Helper functions is_mul(op) and is_div(op).
- Sub-module alu_divider: iterative restoring divider with start/done, magnitude inputs, and quotient/remainder outputs. The top level handles signs, early-outs and the handshake.

Test Plan:
- Integer ops:
  - ADD 0x7FFFFFFF+1 → 0x80000000, zero=0, out_valid one cycle after accept.
  - SUB 5-5 → 0, zero=1.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL 0x80000000 by 4 → 0x08000000.
  - SLL 1 by 33 → 2 (low 5 bits used).
  - SLT with op_a=-1, op_b=1 → 1; SLTU with the same operands → 0.
- Multiply:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MUL -3×7 → 0xFFFFFFEB.
  - Check out_valid at XLEN+1=33 cycles, or 1 with ALU_FAST_MUL_EN.
- Divide:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
  - DIV 0x80000000/-1 → 0x80000000; REM of the same → 0. Both latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a result → result stable, in_ready=0. Then raise out_ready together with a new ADD request → ADD is accepted the same cycle, and its result appears the next cycle.
- Reset mid-divide: assert rst on cycle 10 of a DIVU → next cycle out_valid=0, in_ready=1, result=0. A following ADD 2+3 → 5.
- Illegal op: op=25 → illegal=1, result=0, zero=1, latency 1. The next legal op clears illegal.
